// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder with start/busy/done handshake
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             START,
    input  logic             CIN,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        S_IDLE,
        S_ADD
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_c;
    logic [CW-1:0]    r_cnt;

    logic             w_s;
    logic             w_c_next;
    logic [WIDTH-1:0] w_res_next;

    // Single full-adder cell working on the current LSBs.
    assign w_s        = r_a[0] ^ r_b[0] ^ r_c;
    assign w_c_next   = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
    assign w_res_next = {w_s, r_res[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            SUM     <= '0;
            COUT    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_c     <= CIN;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        BUSY    <= 1'b1;
                        r_state <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_c   <= w_c_next;
                    r_res <= w_res_next;
                    r_cnt <= r_cnt + CW'(1);
                    // SUM/COUT only move here so the partial result stays hidden.
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        SUM     <= w_res_next;
                        COUT    <= w_c_next;
                        DONE    <= 1'b1;
                        BUSY    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    BUSY    <= 1'b0;
                    DONE    <= 1'b0;
                end
            endcase
        end
    end

endmodule
